arith_order_sched: RTL and testbench
====================================

# arith_order_sched

Sequencer in front of the local program generator (the arithmetic control FSMs). It accepts arithmetic requests from the operation unit and shift-I/O requests from the I/O unit, and grants them round-robin. For the winner it issues exactly one order pulse, then waits for the matching answer and reports completion. A missing answer (e.g. division overflow, where the arithmetic control drops back to idle silently) is caught by a watchdog and latched as a sticky fault.

## Interface
- TIMEOUT_CYCLES, 96: WAIT cycles without an answer before a timeout fault; must be ≥ 70, since the longest op (mul/div) needs ~65.
- CNT_W, 7: watchdog counter width; 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-high.
- req_valid_from_op  in  1  level; op request pending.
- req_code_from_op  in  3  0 add, 1 sub, 2 mul, 3 div, 4 and, 5–7 illegal.
- req_ready_to_op  out  1  level; op request may be accepted this cycle.
- req_valid_from_io  in  1  level; I/O shift request pending.
- req_ready_to_io  out  1  level.
- order_add_to_ac / order_sub_to_ac / order_mul_to_ac / order_div_to_ac / order_and_to_ac / order_io_to_ac  out  1 each  one-cycle pulses.
- ac_answer_from_op_path  in  1  pulse; arithmetic answer.
- ac_answer_from_io_path  in  1  pulse; I/O answer.
- do_clear_a_from_pu  in  1  pulse; abort.
- clear_err_from_pnl  in  1  pulse; clears the fault.
- done_to_op  out  1  pulse.
- done_to_io  out  1  pulse.
- err_to_op  out  2  level, sticky: 00 none, 01 timeout, 10 illegal code.
- busy_to_pnl  out  1  level; high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, FAULT. Reset → IDLE.
- Ready: req_ready_to_op = req_ready_to_io = (state == IDLE) && (err == 00). A request is granted at the clock edge where its valid and ready are both high.
- Arbitration:
  - If both requesters are valid in IDLE, the one not granted last wins.
  - last_grant resets to "io", so op wins the first tie.
  - last_grant updates only on a grant.
  - A lone requester always wins.
- On grant, the requester (op/io) and the code are captured.
  - Legal grant → ISSUE.
  - op with code 5–7 → FAULT, err = 10, no order pulse.
- ISSUE (one cycle): exactly the one order_*_to_ac matching the captured request is high. Then → WAIT, with the counter cleared to 0.
- WAIT:
  - The counter increments every cycle.
  - If the matching answer is sampled high → DONE. An op grant matches ac_answer_from_op_path; an io grant matches ac_answer_from_io_path.
  - The non-matching answer is ignored.
  - If the counter reaches TIMEOUT_CYCLES−1 with no answer → FAULT, err = 01.
- DONE (one cycle): done_to_op or done_to_io, whichever matches the grant, is high. Then → IDLE.
- FAULT:
  - No grants; both ready outputs low.
  - clear_err_from_pnl → err = 00 and state → IDLE.
- Abort: do_clear_a_from_pu in any state → IDLE at the next edge.
  - The counter clears and no done pulse is produced.
  - err is left unchanged. If err ≠ 00, the block stays blocked in IDLE until clear_err_from_pnl.
- Priority at any edge: reset > abort > clear_err > answer > timeout.
  - An answer in the same cycle as the timeout edge counts as success.
- Answers sampled in IDLE, ISSUE, DONE or FAULT are ignored.

## Timing
- Reset values:
  - state IDLE, counter 0, last_grant io.
  - All order_* and done_* outputs 0.
  - err_to_op 00, busy_to_pnl 0.
  - Both ready outputs 1.
- Grant at edge T:
  - Order pulse during cycle T+1.
  - WAIT from T+2.
  - Answer sampled at edge A → done pulse during cycle A+1 → IDLE at A+2.
  - Next grant possible at edge A+2.
- All order, done, busy and err outputs are registered; ready is a combinational decode of state and err.
- Timeout: the last legal answer cycle is the (TIMEOUT_CYCLES)th cycle of WAIT. FAULT is visible in the following cycle.
- Throughput: at most one request in flight; 4 + (answer latency) cycles per request.

## Test plan
- Add: op valid, code 0, answer returned 3 cycles after the order → order_add pulse 1 cycle after the grant, done_to_op 1 cycle after the answer, err 00, busy low again.
- Tie: op (code 2) and io valid together from reset → op is granted first and order_mul is pulsed. After its done, io is granted next and order_io is pulsed. With both still valid, op wins the following tie.
- Div overflow: code 3, no answer ever → FAULT after TIMEOUT_CYCLES (96) WAIT cycles, err = 01, ready low, no done. clear_err → IDLE, ready high.
- Illegal code: code 6 → no order pulse, err = 10 the cycle after the grant, busy high until clear_err.
- Abort: code 2 issued, do_clear_a pulsed 10 cycles into WAIT → IDLE at the next edge, no done pulse. A late answer arriving afterwards is ignored.
- Stray answer: io granted, ac_answer_from_op_path pulsed during WAIT → ignored. A later ac_answer_from_io_path → done_to_io.

Source files
------------

// File: rtl/arith_order_sched.sv
// Round-robin order sequencer between the operation/I-O units and the arithmetic control.
// Issues one order pulse per grant, waits for the matching answer, and traps timeouts and illegal codes.
module arith_order_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 96,
    parameter int unsigned CNT_W          = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid_from_op,
    input  logic [2:0] req_code_from_op,
    output logic       req_ready_to_op,
    input  logic       req_valid_from_io,
    output logic       req_ready_to_io,
    output logic       order_add_to_ac,
    output logic       order_sub_to_ac,
    output logic       order_mul_to_ac,
    output logic       order_div_to_ac,
    output logic       order_and_to_ac,
    output logic       order_io_to_ac,
    input  logic       ac_answer_from_op_path,
    input  logic       ac_answer_from_io_path,
    input  logic       do_clear_a_from_pu,
    input  logic       clear_err_from_pnl,
    output logic       done_to_op,
    output logic       done_to_io,
    output logic [1:0] err_to_op,
    output logic       busy_to_pnl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_ILLEGAL = 2'b10
    } err_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4
    } op_code_t;

    state_t           state_q,    state_d;
    err_t             err_q,      err_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             last_io_q,  last_io_d;
    logic             grant_io_q, grant_io_d;
    logic [5:0]       order_q,    order_d;
    logic             done_op_q,  done_op_d;
    logic             done_io_q,  done_io_d;
    logic             busy_q,     busy_d;

    logic ready;
    logic op_win;
    logic io_win;
    logic answer_match;

    assign ready = (state_q == S_IDLE) && (err_q == ERR_NONE);

    // Tie goes to whichever side was not granted last.
    assign op_win = req_valid_from_op && (!req_valid_from_io || last_io_q);
    assign io_win = req_valid_from_io && !op_win;

    assign answer_match = grant_io_q ? ac_answer_from_io_path : ac_answer_from_op_path;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        last_io_d  = last_io_q;
        grant_io_d = grant_io_q;
        order_d    = '0;
        done_op_d  = 1'b0;
        done_io_d  = 1'b0;

        if (do_clear_a_from_pu) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            if (clear_err_from_pnl) begin
                err_d = ERR_NONE;
            end
            case (state_q)
                S_IDLE: begin
                    if (ready && (op_win || io_win)) begin
                        last_io_d  = io_win;
                        grant_io_d = io_win;
                        state_d    = S_ISSUE;
                        if (io_win) begin
                            order_d[5] = 1'b1;
                        end else begin
                            case (req_code_from_op)
                                OP_ADD:  order_d[0] = 1'b1;
                                OP_SUB:  order_d[1] = 1'b1;
                                OP_MUL:  order_d[2] = 1'b1;
                                OP_DIV:  order_d[3] = 1'b1;
                                OP_AND:  order_d[4] = 1'b1;
                                default: begin
                                    state_d = S_FAULT;
                                    err_d   = ERR_ILLEGAL;
                                end
                            endcase
                        end
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
                S_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Answer on the final watchdog cycle still counts as success.
                    if (answer_match) begin
                        state_d   = S_DONE;
                        done_op_d = !grant_io_q;
                        done_io_d = grant_io_q;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_FAULT;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_FAULT: begin
                    if (clear_err_from_pnl) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
            last_io_q  <= 1'b1;
            grant_io_q <= 1'b0;
            order_q    <= '0;
            done_op_q  <= 1'b0;
            done_io_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            last_io_q  <= last_io_d;
            grant_io_q <= grant_io_d;
            order_q    <= order_d;
            done_op_q  <= done_op_d;
            done_io_q  <= done_io_d;
            busy_q     <= busy_d;
        end
    end

    assign req_ready_to_op = ready;
    assign req_ready_to_io = ready;
    assign order_add_to_ac = order_q[0];
    assign order_sub_to_ac = order_q[1];
    assign order_mul_to_ac = order_q[2];
    assign order_div_to_ac = order_q[3];
    assign order_and_to_ac = order_q[4];
    assign order_io_to_ac  = order_q[5];
    assign done_to_op      = done_op_q;
    assign done_to_io      = done_io_q;
    assign err_to_op       = err_q;
    assign busy_to_pnl     = busy_q;

endmodule

// File: tb/tb_arith_order_sched.sv
// Directed bench for arith_order_sched: arbitration, order/done timing, watchdog, illegal code, abort.
module tb_arith_order_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid_from_op;
    logic [2:0] req_code_from_op;
    logic       req_ready_to_op;
    logic       req_valid_from_io;
    logic       req_ready_to_io;
    logic       order_add_to_ac, order_sub_to_ac, order_mul_to_ac;
    logic       order_div_to_ac, order_and_to_ac, order_io_to_ac;
    logic       ac_answer_from_op_path;
    logic       ac_answer_from_io_path;
    logic       do_clear_a_from_pu;
    logic       clear_err_from_pnl;
    logic       done_to_op;
    logic       done_to_io;
    logic [1:0] err_to_op;
    logic       busy_to_pnl;

    int checks = 0;
    int errors = 0;

    logic [5:0] ord_v;
    logic [5:0] exp_ord [0:4] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000};

    assign ord_v = {order_io_to_ac, order_and_to_ac, order_div_to_ac,
                    order_mul_to_ac, order_sub_to_ac, order_add_to_ac};

    always #5 clk = ~clk;

    arith_order_sched #(.TIMEOUT_CYCLES(96), .CNT_W(7)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_valid_from_op      (req_valid_from_op),
        .req_code_from_op       (req_code_from_op),
        .req_ready_to_op        (req_ready_to_op),
        .req_valid_from_io      (req_valid_from_io),
        .req_ready_to_io        (req_ready_to_io),
        .order_add_to_ac        (order_add_to_ac),
        .order_sub_to_ac        (order_sub_to_ac),
        .order_mul_to_ac        (order_mul_to_ac),
        .order_div_to_ac        (order_div_to_ac),
        .order_and_to_ac        (order_and_to_ac),
        .order_io_to_ac         (order_io_to_ac),
        .ac_answer_from_op_path (ac_answer_from_op_path),
        .ac_answer_from_io_path (ac_answer_from_io_path),
        .do_clear_a_from_pu     (do_clear_a_from_pu),
        .clear_err_from_pnl     (clear_err_from_pnl),
        .done_to_op             (done_to_op),
        .done_to_io             (done_to_io),
        .err_to_op              (err_to_op),
        .busy_to_pnl            (busy_to_pnl)
    );

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid_from_op = 1'b0; req_code_from_op = 3'd0; req_valid_from_io = 1'b0;
        ac_answer_from_op_path = 1'b0; ac_answer_from_io_path = 1'b0;
        do_clear_a_from_pu = 1'b0; clear_err_from_pnl = 1'b0;
        #2;
        checks++; if (ord_v !== 6'b0) begin errors++; $display("FAIL reset_orders got %b exp 000000", ord_v); end
        checks++; if ({done_to_op, done_to_io} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {done_to_op, done_to_io}); end
        checks++; if (err_to_op !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", err_to_op); end
        checks++; if (busy_to_pnl !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_to_pnl); end
        checks++; if ({req_ready_to_op, req_ready_to_io} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", {req_ready_to_op, req_ready_to_io}); end
        cyc();
        reset = 1'b0;
        cyc();
        checks++; if ({busy_to_pnl, req_ready_to_op} !== 2'b01) begin errors++; $display("FAIL post_reset_idle got %b exp 01", {busy_to_pnl, req_ready_to_op}); end
    endtask

    task automatic test_tie();
        req_valid_from_op = 1'b1; req_code_from_op = 3'd2; req_valid_from_io = 1'b1;
        cyc();
        checks++; if (ord_v !== 6'b000100) begin errors++; $display("FAIL tie1_order got %b exp 000100", ord_v); end
        checks++; if (req_ready_to_op !== 1'b0) begin errors++; $display("FAIL tie1_ready got %b exp 0", req_ready_to_op); end
        cyc();
        ac_answer_from_op_path = 1'b1;
        cyc();
        ac_answer_from_op_path = 1'b0;
        checks++; if ({done_to_op, done_to_io} !== 2'b10) begin errors++; $display("FAIL tie1_done got %b exp 10", {done_to_op, done_to_io}); end
        cyc();
        cyc();
        checks++; if (ord_v !== 6'b100000) begin errors++; $display("FAIL tie2_order got %b exp 100000", ord_v); end
        cyc();
        ac_answer_from_io_path = 1'b1;
        cyc();
        ac_answer_from_io_path = 1'b0;
        checks++; if ({done_to_op, done_to_io} !== 2'b01) begin errors++; $display("FAIL tie2_done got %b exp 01", {done_to_op, done_to_io}); end
        cyc();
        cyc();
        checks++; if (ord_v !== 6'b000100) begin errors++; $display("FAIL tie3_order got %b exp 000100", ord_v); end
        req_valid_from_op = 1'b0; req_valid_from_io = 1'b0;
        do_clear_a_from_pu = 1'b1;
        cyc();
        do_clear_a_from_pu = 1'b0;
        checks++; if (busy_to_pnl !== 1'b0) begin errors++; $display("FAIL tie_abort_busy got %b exp 0", busy_to_pnl); end
    endtask

    task automatic test_add();
        req_valid_from_op = 1'b1; req_code_from_op = 3'd0;
        cyc();
        req_valid_from_op = 1'b0;
        checks++; if (ord_v !== 6'b000001) begin errors++; $display("FAIL add_order got %b exp 000001", ord_v); end
        checks++; if (busy_to_pnl !== 1'b1) begin errors++; $display("FAIL add_busy got %b exp 1", busy_to_pnl); end
        cyc();
        checks++; if (ord_v !== 6'b0) begin errors++; $display("FAIL add_order_single got %b exp 000000", ord_v); end
        cyc();
        cyc();
        checks++; if (done_to_op !== 1'b0) begin errors++; $display("FAIL add_early_done got %b exp 0", done_to_op); end
        ac_answer_from_op_path = 1'b1;
        cyc();
        ac_answer_from_op_path = 1'b0;
        checks++; if ({done_to_op, done_to_io, err_to_op} !== 4'b1000) begin errors++; $display("FAIL add_done got %b exp 1000", {done_to_op, done_to_io, err_to_op}); end
        cyc();
        checks++; if ({done_to_op, busy_to_pnl, req_ready_to_op} !== 3'b001) begin errors++; $display("FAIL add_idle got %b exp 001", {done_to_op, busy_to_pnl, req_ready_to_op}); end
    endtask

    task automatic test_codes();
        for (int c = 0; c < 5; c++) begin
            req_valid_from_op = 1'b1; req_code_from_op = 3'(c);
            cyc();
            req_valid_from_op = 1'b0;
            checks++; if (ord_v !== exp_ord[c]) begin errors++; $display("FAIL code%0d_order got %b exp %b", c, ord_v, exp_ord[c]); end
            cyc();
            ac_answer_from_op_path = 1'b1;
            cyc();
            ac_answer_from_op_path = 1'b0;
            checks++; if (done_to_op !== 1'b1) begin errors++; $display("FAIL code%0d_done got %b exp 1", c, done_to_op); end
            cyc();
        end
    endtask

    task automatic test_div_timeout();
        int bad = 0;
        req_valid_from_op = 1'b1; req_code_from_op = 3'd3;
        cyc();
        req_valid_from_op = 1'b0;
        checks++; if (ord_v !== 6'b001000) begin errors++; $display("FAIL div_order got %b exp 001000", ord_v); end
        for (int i = 0; i < 96; i++) begin
            cyc();
            if (err_to_op !== 2'b00 || done_to_op !== 1'b0 || busy_to_pnl !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL div_wait_window got %0d bad cycles exp 0", bad); end
        cyc();
        checks++; if ({err_to_op, req_ready_to_op, req_ready_to_io, busy_to_pnl, done_to_op} !== 6'b010010) begin errors++; $display("FAIL div_timeout got %b exp 010010", {err_to_op, req_ready_to_op, req_ready_to_io, busy_to_pnl, done_to_op}); end
        req_valid_from_op = 1'b1; req_code_from_op = 3'd0; req_valid_from_io = 1'b1;
        cyc();
        req_valid_from_op = 1'b0; req_valid_from_io = 1'b0;
        checks++; if ({ord_v, err_to_op} !== 8'b00000001) begin errors++; $display("FAIL fault_no_grant got %b exp 00000001", {ord_v, err_to_op}); end
        clear_err_from_pnl = 1'b1;
        cyc();
        clear_err_from_pnl = 1'b0;
        checks++; if ({err_to_op, req_ready_to_op, busy_to_pnl} !== 4'b0010) begin errors++; $display("FAIL div_clear got %b exp 0010", {err_to_op, req_ready_to_op, busy_to_pnl}); end
    endtask

    task automatic test_answer_at_limit();
        req_valid_from_op = 1'b1; req_code_from_op = 3'd3;
        cyc();
        req_valid_from_op = 1'b0;
        for (int i = 0; i < 96; i++) cyc();
        ac_answer_from_op_path = 1'b1;
        cyc();
        ac_answer_from_op_path = 1'b0;
        checks++; if ({done_to_op, err_to_op} !== 3'b100) begin errors++; $display("FAIL limit_answer got %b exp 100", {done_to_op, err_to_op}); end
        cyc();
        checks++; if ({busy_to_pnl, req_ready_to_op, err_to_op} !== 4'b0100) begin errors++; $display("FAIL limit_idle got %b exp 0100", {busy_to_pnl, req_ready_to_op, err_to_op}); end
    endtask

    task automatic test_illegal();
        req_valid_from_op = 1'b1; req_code_from_op = 3'd6;
        cyc();
        req_valid_from_op = 1'b0;
        checks++; if ({ord_v, err_to_op, busy_to_pnl, req_ready_to_op} !== 10'b0000001010) begin errors++; $display("FAIL illegal_grant got %b exp 0000001010", {ord_v, err_to_op, busy_to_pnl, req_ready_to_op}); end
        cyc();
        cyc();
        checks++; if ({ord_v, err_to_op, busy_to_pnl} !== 9'b000000101) begin errors++; $display("FAIL illegal_hold got %b exp 000000101", {ord_v, err_to_op, busy_to_pnl}); end
        clear_err_from_pnl = 1'b1;
        cyc();
        clear_err_from_pnl = 1'b0;
        checks++; if ({err_to_op, busy_to_pnl, req_ready_to_op} !== 4'b0001) begin errors++; $display("FAIL illegal_clear got %b exp 0001", {err_to_op, busy_to_pnl, req_ready_to_op}); end
    endtask

    task automatic test_abort();
        req_valid_from_op = 1'b1; req_code_from_op = 3'd2;
        cyc();
        req_valid_from_op = 1'b0;
        checks++; if (ord_v !== 6'b000100) begin errors++; $display("FAIL abort_order got %b exp 000100", ord_v); end
        for (int i = 0; i < 10; i++) cyc();
        do_clear_a_from_pu = 1'b1;
        cyc();
        do_clear_a_from_pu = 1'b0;
        checks++; if ({busy_to_pnl, done_to_op, req_ready_to_op, err_to_op} !== 5'b00100) begin errors++; $display("FAIL abort_idle got %b exp 00100", {busy_to_pnl, done_to_op, req_ready_to_op, err_to_op}); end
        ac_answer_from_op_path = 1'b1;
        cyc();
        ac_answer_from_op_path = 1'b0;
        cyc();
        checks++; if ({done_to_op, done_to_io, busy_to_pnl} !== 3'b000) begin errors++; $display("FAIL abort_late_answer got %b exp 000", {done_to_op, done_to_io, busy_to_pnl}); end
    endtask

    task automatic test_abort_blocked();
        req_valid_from_op = 1'b1; req_code_from_op = 3'd7;
        cyc();
        req_valid_from_op = 1'b0;
        do_clear_a_from_pu = 1'b1;
        cyc();
        do_clear_a_from_pu = 1'b0;
        checks++; if ({err_to_op, busy_to_pnl, req_ready_to_op} !== 4'b1000) begin errors++; $display("FAIL abort_keeps_err got %b exp 1000", {err_to_op, busy_to_pnl, req_ready_to_op}); end
        req_valid_from_io = 1'b1;
        cyc();
        req_valid_from_io = 1'b0;
        checks++; if ({ord_v, busy_to_pnl} !== 7'b0000000) begin errors++; $display("FAIL blocked_no_grant got %b exp 0000000", {ord_v, busy_to_pnl}); end
        clear_err_from_pnl = 1'b1;
        cyc();
        clear_err_from_pnl = 1'b0;
        checks++; if ({err_to_op, req_ready_to_io} !== 3'b001) begin errors++; $display("FAIL blocked_clear got %b exp 001", {err_to_op, req_ready_to_io}); end
    endtask

    task automatic test_stray();
        req_valid_from_io = 1'b1;
        cyc();
        req_valid_from_io = 1'b0;
        checks++; if (ord_v !== 6'b100000) begin errors++; $display("FAIL stray_order got %b exp 100000", ord_v); end
        cyc();
        ac_answer_from_op_path = 1'b1;
        cyc();
        ac_answer_from_op_path = 1'b0;
        checks++; if ({done_to_op, done_to_io, busy_to_pnl} !== 3'b001) begin errors++; $display("FAIL stray_ignored got %b exp 001", {done_to_op, done_to_io, busy_to_pnl}); end
        cyc();
        ac_answer_from_io_path = 1'b1;
        cyc();
        ac_answer_from_io_path = 1'b0;
        checks++; if ({done_to_op, done_to_io} !== 2'b01) begin errors++; $display("FAIL stray_io_done got %b exp 01", {done_to_op, done_to_io}); end
        cyc();
        checks++; if ({done_to_io, busy_to_pnl, req_ready_to_io} !== 3'b001) begin errors++; $display("FAIL stray_idle got %b exp 001", {done_to_io, busy_to_pnl, req_ready_to_io}); end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_add();
        test_codes();
        test_div_timeout();
        test_answer_at_limit();
        test_illegal();
        test_abort();
        test_abort_blocked();
        test_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
